// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the layer sequencer and its MAC slave map.
//   WEIGHT_BUFFER_SIZE / IMAGE_BUFFER_SIZE : MAC slave window sizes (words)
//   MAC_RESULT_ADDR : result register word address (after both windows)
//   MAC_AW          : MAC slave word-address width
//   fp32_t          : raw IEEE-754 single word
//   seq_state_t     : sequencer FSM states
//   clog2_min1      : $clog2 clamped to 1 so single-entry ranges still get a bit
package mac_pkg;

  localparam int unsigned WEIGHT_BUFFER_SIZE = 96;
  localparam int unsigned IMAGE_BUFFER_SIZE  = 96;
  localparam int unsigned MAC_RESULT_ADDR    = WEIGHT_BUFFER_SIZE + IMAGE_BUFFER_SIZE;
  localparam int unsigned MAC_AW             = 11;

  typedef logic [31:0] fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    W_FETCH,
    W_WRITE,
    I_FETCH,
    I_WRITE,
    R_READ,
    R_OUT,
    DONE
  } seq_state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mac_layer_sequencer_counter.sv
// seq_counter: up-counter with synchronous clear, enable and terminal flag.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : force count to 0 (wins over en_i)
//   en_i           : advance; wraps to 0 when advancing from LAST
//   cnt_o          : current count
//   tc_o           : count == LAST
module seq_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAST  = 15
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST_V);

endmodule

// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer: Avalon-MM master that runs a full fully-connected layer
// through the single-neuron MAC slave. Per neuron: write VEC_LEN weights to
// address 0, then VEC_LEN image words to WEIGHT_BUFFER_SIZE, then read the
// result register and emit it tagged with the neuron index.
//   clk, reset            : clock, synchronous active-high reset
//   start / busy / done   : run control (start only honoured in IDLE)
//   wmem_* / imem_*       : local weight / image memory read ports (1-cycle latency)
//   m_*                   : Avalon-MM master to the MAC slave
//   res_valid/index/data  : one-cycle result strobe per neuron
module mac_layer_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned VEC_LEN            = 96,
  parameter int unsigned NUM_NEURONS        = 10,
  parameter int unsigned WEIGHT_BUFFER_SIZE = mac_pkg::WEIGHT_BUFFER_SIZE,
  parameter int unsigned IMAGE_BUFFER_SIZE  = mac_pkg::IMAGE_BUFFER_SIZE,
  parameter int unsigned W_AW               = 10,
  parameter int unsigned I_AW               = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 wmem_rd,
  output logic [W_AW-1:0]                      wmem_addr,
  input  logic [31:0]                          wmem_rdata,
  output logic                                 imem_rd,
  output logic [I_AW-1:0]                      imem_addr,
  input  logic [31:0]                          imem_rdata,
  output logic [MAC_AW-1:0]                    m_address,
  output logic [31:0]                          m_writedata,
  output logic                                 m_write,
  output logic                                 m_read,
  input  logic [31:0]                          m_readdata,
  input  logic                                 m_waitrequest,
  output logic                                 res_valid,
  output logic [clog2_min1(NUM_NEURONS)-1:0]   res_index,
  output logic [31:0]                          res_data
);

  localparam int unsigned KW = clog2_min1(VEC_LEN);
  localparam int unsigned NW = clog2_min1(NUM_NEURONS);

  // Window addresses come from this instance's parameters, not the package
  // defaults, so an overridden buffer size moves the image/result windows too.
  localparam logic [MAC_AW-1:0] W_ADDR = '0;
  localparam logic [MAC_AW-1:0] I_ADDR = MAC_AW'(WEIGHT_BUFFER_SIZE);
  localparam logic [MAC_AW-1:0] R_ADDR = MAC_AW'(WEIGHT_BUFFER_SIZE + IMAGE_BUFFER_SIZE);

  seq_state_t      state_q, state_d;
  logic [KW-1:0]   k_cnt;
  logic            k_tc, k_inc;
  logic [NW-1:0]   n_cnt;
  logic            n_tc, n_inc;
  logic            run_start;
  logic [W_AW-1:0] base_q, base_d;   // running n*VEC_LEN
  logic            ent_q;            // first cycle of a write state
  fp32_t           hold_q, wdata;
  fp32_t           res_q, res_d;

  assign run_start = (state_q == IDLE) && start;

  // Word counter k (within a vector) and neuron counter n.
  seq_counter #(.WIDTH(KW), .LAST(VEC_LEN - 1)) u_k (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (run_start),
    .en_i    (k_inc),
    .cnt_o   (k_cnt),
    .tc_o    (k_tc)
  );

  seq_counter #(.WIDTH(NW), .LAST(NUM_NEURONS - 1)) u_n (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (run_start),
    .en_i    (n_inc),
    .cnt_o   (n_cnt),
    .tc_o    (n_tc)
  );

  // Memory data is only valid the cycle after the fetch, so the first write
  // cycle takes it straight from the memory and later (stalled) cycles replay
  // the held copy. This keeps writedata stable across waitrequest without
  // spending an extra capture cycle per word.
  always_comb begin
    if (ent_q) wdata = (state_q == I_WRITE) ? imem_rdata : wmem_rdata;
    else       wdata = hold_q;
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    done        = 1'b0;
    wmem_rd     = 1'b0;
    wmem_addr   = '0;
    imem_rd     = 1'b0;
    imem_addr   = '0;
    m_address   = '0;
    m_writedata = '0;
    m_write     = 1'b0;
    m_read      = 1'b0;
    res_valid   = 1'b0;
    res_index   = '0;
    k_inc       = 1'b0;
    n_inc       = 1'b0;
    base_d      = base_q;
    res_d       = res_q;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          base_d  = '0;
          state_d = W_FETCH;
        end
      end
      W_FETCH: begin
        wmem_rd   = 1'b1;
        wmem_addr = base_q + W_AW'(k_cnt);
        state_d   = W_WRITE;
      end
      W_WRITE: begin
        m_write     = 1'b1;
        m_address   = W_ADDR;
        m_writedata = wdata;
        if (!m_waitrequest) begin
          k_inc   = 1'b1;
          state_d = k_tc ? I_FETCH : W_FETCH;
        end
      end
      I_FETCH: begin
        imem_rd   = 1'b1;
        imem_addr = I_AW'(k_cnt);
        state_d   = I_WRITE;
      end
      I_WRITE: begin
        m_write     = 1'b1;
        m_address   = I_ADDR;
        m_writedata = wdata;
        if (!m_waitrequest) begin
          k_inc   = 1'b1;
          state_d = k_tc ? R_READ : I_FETCH;
        end
      end
      R_READ: begin
        // The slave holds waitrequest until its accumulator has drained.
        m_read    = 1'b1;
        m_address = R_ADDR;
        if (!m_waitrequest) begin
          res_d   = m_readdata;
          state_d = R_OUT;
        end
      end
      R_OUT: begin
        res_valid = 1'b1;
        res_index = n_cnt;
        n_inc     = 1'b1;
        if (n_tc) begin
          state_d = DONE;
        end else begin
          base_d  = base_q + W_AW'(VEC_LEN);
          state_d = W_FETCH;
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      ent_q   <= 1'b0;
      hold_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ent_q   <= (state_q == W_FETCH) || (state_q == I_FETCH);
      hold_q  <= wdata;
      res_q   <= res_d;
    end
  end

  assign res_data = res_q;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
module tb_mac_layer_sequencer;
  import mac_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b, stall_en;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, st_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- DUT A: VEC_LEN=4, NUM_NEURONS=2 ----------------
  logic        a_busy, a_done, a_wmem_rd, a_imem_rd, a_m_write, a_m_read, a_res_valid;
  logic [9:0]  a_wmem_addr;
  logic [6:0]  a_imem_addr;
  logic [10:0] a_m_address;
  logic [31:0] a_wmem_rdata, a_imem_rdata, a_m_writedata, a_m_readdata, a_res_data;
  logic        a_m_waitrequest;
  logic [0:0]  a_res_index;

  mac_layer_sequencer #(.VEC_LEN(4), .NUM_NEURONS(2), .W_AW(10), .I_AW(7)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
    .wmem_rd(a_wmem_rd), .wmem_addr(a_wmem_addr), .wmem_rdata(a_wmem_rdata),
    .imem_rd(a_imem_rd), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
    .m_address(a_m_address), .m_writedata(a_m_writedata), .m_write(a_m_write),
    .m_read(a_m_read), .m_readdata(a_m_readdata), .m_waitrequest(a_m_waitrequest),
    .res_valid(a_res_valid), .res_index(a_res_index), .res_data(a_res_data)
  );

  // Memories: valid data only one cycle after a read, garbage otherwise/out of range.
  always @(posedge clk) begin
    a_wmem_rdata <= a_wmem_rd ? ((a_wmem_addr < 10'd8) ? 32'h3F800000 : 32'h0BADBAD0) : 32'h5555AAAA;
    a_imem_rdata <= a_imem_rd ? ((a_imem_addr < 7'd4)  ? 32'h40000000 : 32'h0BADBAD1) : 32'hAAAA5555;
  end

  // MAC slave: optional stall of 3 cycles per write, 5 per read.
  int a_scnt = 0;
  assign a_m_waitrequest = stall_en && (a_m_write || a_m_read) && (a_scnt < (a_m_read ? 5 : 3));
  assign a_m_readdata    = a_m_waitrequest ? 32'hDEADBEEF : 32'h41000000;
  always @(posedge clk) a_scnt <= (reset || !a_m_waitrequest) ? 0 : a_scnt + 1;

  wire [44:0] a_bus = {a_m_address, a_m_writedata, a_m_write, a_m_read};
  logic       a_pw = 1'b0;
  logic [44:0] a_pbus;
  int a_txn[$], a_waddr[$], a_ridx[$], a_rcyc[$], a_dcyc[$];
  logic [31:0] a_rdat[$];

  always @(negedge clk) begin
    if (reset) a_pw = 1'b0;
    else begin
      chk("rw_excl", 64'(a_m_write & a_m_read), 64'd0);
      if (a_pw) chk("stall_hold", 64'(a_bus), 64'(a_pbus));
      a_pw   = a_m_waitrequest;
      a_pbus = a_bus;
      if (a_m_write && !a_m_waitrequest) begin
        a_txn.push_back(int'(a_m_address));
        chk("wr_data", 64'(a_m_writedata), (a_m_address == 11'd0) ? 64'h3F800000 : 64'h40000000);
      end
      if (a_m_read && !a_m_waitrequest) a_txn.push_back(int'(a_m_address));
      if (a_wmem_rd) a_waddr.push_back(int'(a_wmem_addr));
      if (a_res_valid) begin
        a_ridx.push_back(int'(a_res_index));
        a_rdat.push_back(a_res_data);
        a_rcyc.push_back(cyc);
      end
      if (a_done) a_dcyc.push_back(cyc);
    end
  end

  // ---------------- DUT B: VEC_LEN=1, NUM_NEURONS=1 ----------------
  logic        b_busy, b_done, b_wmem_rd, b_imem_rd, b_m_write, b_m_read, b_res_valid;
  logic [3:0]  b_wmem_addr, b_imem_addr;
  logic [10:0] b_m_address;
  logic [31:0] b_wmem_rdata, b_imem_rdata, b_m_writedata, b_m_readdata, b_res_data;
  logic        b_m_waitrequest;
  logic [0:0]  b_res_index;

  mac_layer_sequencer #(.VEC_LEN(1), .NUM_NEURONS(1), .W_AW(4), .I_AW(4)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .wmem_rd(b_wmem_rd), .wmem_addr(b_wmem_addr), .wmem_rdata(b_wmem_rdata),
    .imem_rd(b_imem_rd), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
    .m_address(b_m_address), .m_writedata(b_m_writedata), .m_write(b_m_write),
    .m_read(b_m_read), .m_readdata(b_m_readdata), .m_waitrequest(b_m_waitrequest),
    .res_valid(b_res_valid), .res_index(b_res_index), .res_data(b_res_data)
  );

  always @(posedge clk) begin
    b_wmem_rdata <= b_wmem_rd ? ((b_wmem_addr == 4'd0) ? 32'h40400000 : 32'h0BADBAD2) : 32'h5555AAAA;
    b_imem_rdata <= b_imem_rd ? ((b_imem_addr == 4'd0) ? 32'hC0000000 : 32'h0BADBAD3) : 32'hAAAA5555;
  end
  assign b_m_waitrequest = 1'b0;
  assign b_m_readdata    = b_m_read ? 32'hC0C00000 : 32'h0;

  int b_txn[$], b_ridx[$], b_rcyc[$], b_dcyc[$];
  logic [31:0] b_rdat[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (b_m_write) begin
        b_txn.push_back(int'(b_m_address));
        chk("b_wr_data", 64'(b_m_writedata), (b_m_address == 11'd0) ? 64'h40400000 : 64'hC0000000);
      end
      if (b_m_read) b_txn.push_back(int'(b_m_address));
      if (b_res_valid) begin
        b_ridx.push_back(int'(b_res_index));
        b_rdat.push_back(b_res_data);
        b_rcyc.push_back(cyc);
      end
      if (b_done) b_dcyc.push_back(cyc);
    end
  end

  // ---------------- helpers ----------------
  task automatic clr_a();
    a_txn.delete(); a_waddr.delete(); a_ridx.delete();
    a_rcyc.delete(); a_dcyc.delete(); a_rdat.delete();
  endtask

  task automatic pulse_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    st_cyc  = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("busy_after_start", 64'(a_busy), 64'd1);
  endtask

  task automatic wait_a(input int budget);
    int i;
    i = 0;
    while (a_dcyc.size() == 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", 64'(a_dcyc.size() != 0), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_a_idle(input string tag);
    chk(tag, 64'({a_busy, a_done, a_wmem_rd, a_wmem_addr, a_imem_rd, a_imem_addr,
                  a_m_address, a_m_write, a_m_read, a_res_valid, a_res_index}), 64'd0);
    chk({tag, "_data"}, 64'({a_m_writedata, a_res_data}), 64'd0);
  endtask

  // Full-run check for DUT A: results, latency, Avalon and memory address order.
  task automatic check_run(input int lat, input int gap);
    int j, e;
    chk("res_cnt", 64'(a_ridx.size()), 64'd2);
    chk("done_cnt", 64'(a_dcyc.size()), 64'd1);
    if (a_ridx.size() == 2 && a_dcyc.size() == 1) begin
      for (int n = 0; n < 2; n++) begin
        chk("res_idx", 64'(a_ridx[n]), 64'(n));
        chk("res_data", 64'(a_rdat[n]), 64'h41000000);
      end
      chk("lat_first", 64'(a_rcyc[0] - st_cyc), 64'(lat));
      chk("lat_gap", 64'(a_rcyc[1] - a_rcyc[0]), 64'(gap));
      chk("done_lat", 64'(a_dcyc[0] - a_rcyc[1]), 64'd1);
    end
    chk("txn_cnt", 64'(a_txn.size()), 64'd18);
    if (a_txn.size() == 18)
      for (int i = 0; i < 18; i++) begin
        j = i % 9;
        e = (j < 4) ? 0 : (j < 8) ? 96 : 192;
        chk("txn_addr", 64'(a_txn[i]), 64'(e));
      end
    chk("waddr_cnt", 64'(a_waddr.size()), 64'd8);
    if (a_waddr.size() == 8)
      for (int i = 0; i < 8; i++) chk("wmem_addr", 64'(a_waddr[i]), 64'(i));
    chk("busy_end", 64'(a_busy), 64'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    bit found;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_a_idle("reset_a");
    chk("reset_b", 64'({b_busy, b_done, b_m_write, b_m_read, b_res_valid, b_res_data}), 64'd0);
    reset = 1'b0;

    // Unstalled run: 4*4+1+0+1 = 18 cycles per neuron.
    clr_a();
    pulse_a();
    wait_a(200);
    check_run(18, 18);

    // Stalled run: +12 write stall +12 image stall +5 read stall per neuron.
    stall_en = 1'b1;
    clr_a();
    pulse_a();
    wait_a(400);
    check_run(47, 47);
    stall_en = 1'b0;

    // Extra start while busy must be ignored.
    clr_a();
    pulse_a();
    repeat (8) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_a(200);
    repeat (40) @(negedge clk);
    chk("restart_res_cnt", 64'(a_ridx.size()), 64'd2);
    chk("restart_done_cnt", 64'(a_dcyc.size()), 64'd1);
    chk("restart_busy", 64'(a_busy), 64'd0);

    // Reset during neuron 1 image writes abandons the run.
    clr_a();
    pulse_a();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (a_ridx.size() == 1 && a_m_write && a_m_address == 11'd96) found = 1'b1;
    end
    chk("reach_iwrite_n1", 64'(found), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_a_idle("midrun_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abandon_res_cnt", 64'(a_ridx.size()), 64'd1);
    chk("abandon_done_cnt", 64'(a_dcyc.size()), 64'd0);
    clr_a();
    pulse_a();
    wait_a(200);
    check_run(18, 18);

    // Single word, single neuron: 3.0 * -2.0 = -6.0.
    @(posedge clk); #1;
    start_b = 1'b1;
    st_cyc  = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 50 && b_dcyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("b_res_cnt", 64'(b_ridx.size()), 64'd1);
    chk("b_done_cnt", 64'(b_dcyc.size()), 64'd1);
    if (b_ridx.size() == 1 && b_dcyc.size() == 1) begin
      chk("b_res_data", 64'(b_rdat[0]), 64'hC0C00000);
      chk("b_res_idx", 64'(b_ridx[0]), 64'd0);
      chk("b_lat", 64'(b_rcyc[0] - st_cyc), 64'd6);
      chk("b_done_lat", 64'(b_dcyc[0] - b_rcyc[0]), 64'd1);
    end
    chk("b_txn_cnt", 64'(b_txn.size()), 64'd3);
    if (b_txn.size() == 3) begin
      chk("b_txn0", 64'(b_txn[0]), 64'd0);
      chk("b_txn1", 64'(b_txn[1]), 64'd96);
      chk("b_txn2", 64'(b_txn[2]), 64'd192);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_layer_sequencer.md
Name: mac_layer_sequencer

Overview:
Avalon-MM master that sequences the single-neuron floating-point MAC slave through a full fully-connected layer. For each neuron it streams that neuron's weight vector, then the shared input vector, into the MAC slave. It then reads the MAC result register, honouring waitrequest, and emits the result with its neuron index. It sits between the local weight/image memories and the MAC slave on the fabric.

Parameters:
VEC_LEN, 96, words per neuron vector; legal range 1..WEIGHT_BUFFER_SIZE
NUM_NEURONS, 10, neurons per layer run
WEIGHT_BUFFER_SIZE, 96, MAC weight window base/size (weight writes go to address 0)
IMAGE_BUFFER_SIZE, 96, MAC image window size (image writes go to WEIGHT_BUFFER_SIZE)
W_AW, 10, weight memory address width; must satisfy 2^W_AW >= NUM_NEURONS*VEC_LEN
I_AW, 7, image memory address width; must satisfy 2^I_AW >= VEC_LEN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a layer run when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last result is emitted
wmem_rd  out  1  weight memory read strobe
wmem_addr  out  W_AW  weight address = neuron*VEC_LEN + k
wmem_rdata  in  32  weight data, valid 1 cycle after wmem_rd
imem_rd  out  1  image memory read strobe
imem_addr  out  I_AW  image address = k
imem_rdata  in  32  image data, valid 1 cycle after imem_rd
m_address  out  11  MAC slave word address
m_writedata  out  32  MAC write data
m_write  out  1  MAC write request
m_read  out  1  MAC read request
m_readdata  in  32  MAC read data
m_waitrequest  in  1  MAC stall
res_valid  out  1  one-cycle result strobe
res_index  out  $clog2(NUM_NEURONS)  neuron number of res_data
res_data  out  32  IEEE-754 MAC result

Behaviour:
- One clock, clk. Synchronous active-high reset: FSM to IDLE; counters cleared; all outputs 0.
- Reset mid-run abandons the run immediately: no res_valid, no done. Host software must reset the MAC slave too.
- FSM states: IDLE, W_FETCH, W_WRITE, I_FETCH, I_WRITE, R_READ, R_OUT, DONE.
- IDLE: on start go to W_FETCH with n=0, k=0. busy=0. start is ignored in all other states.
- W_FETCH: wmem_rd=1, wmem_addr=n*VEC_LEN+k. Next state W_WRITE.
- W_WRITE: m_write=1, m_address=0, m_writedata=wmem_rdata, captured into a holding register on state entry.
  - While m_waitrequest is high, hold the state and all outputs stable.
  - On acceptance: if k==VEC_LEN-1, set k=0 and go to I_FETCH; else k++ and go to W_FETCH.
- I_FETCH / I_WRITE: same pattern with imem, m_address=WEIGHT_BUFFER_SIZE.
  - After the last word, go to R_READ.
- Ordering is mandatory. The MAC pops its weight and image FIFOs together whenever the image FIFO is non-empty, so every weight for a neuron must be written before that neuron's first image word.
- R_READ: m_read=1, m_address=WEIGHT_BUFFER_SIZE+IMAGE_BUFFER_SIZE.
  - Hold while m_waitrequest=1. The MAC stalls until its accumulation pipeline drains.
  - On the cycle with m_waitrequest=0, capture m_readdata into res_data and go to R_OUT.
- R_OUT: res_valid=1 for one cycle, res_index=n.
  - If n==NUM_NEURONS-1 go to DONE; else n++ and go to W_FETCH.
- DONE: done=1 for one cycle, busy=0, then IDLE. busy is high in every state except IDLE and DONE.
- m_write and m_read are never high together.
- Unstalled latency per neuron is 4*VEC_LEN + 1 + (read stall) + 1 cycles.
- Address arithmetic uses n*VEC_LEN computed as a running base register: add VEC_LEN per neuron, no multiplier. The base resets to 0 on start.
- VEC_LEN=1 and NUM_NEURONS=1 are legal and must work; there are no zero-length loops.

Decomposition:
- Shared package mac_pkg holds:
  - WEIGHT_BUFFER_SIZE, IMAGE_BUFFER_SIZE, and MAC_RESULT_ADDR = their sum.
  - The FSM state enum seq_state_t.
  - The 32-bit word type fp32_t.
- One natural sub-module: seq_counter, a parameterised up-counter with clear, enable and terminal-count flag. It is instantiated for k and for n.
- The FSM and Avalon master logic stay in the top.

Test Plan:
1. VEC_LEN=4, NUM_NEURONS=2; all weights 0x3F800000 (1.0), image 0x40000000 (2.0); real MAC slave -> res_data 0x41000000 (8.0) for index 0 then index 1; done one cycle after the second res_valid.
2. Protocol check on test 1 -> per neuron exactly 4 writes to address 0, then 4 to address 96, then 1 read at address 192; wmem_addr sequence 0..3 then 4..7.
3. Slave model asserting m_waitrequest 3 cycles on each write and 5 cycles on the read -> outputs held stable during stalls; results identical to test 1; per-neuron latency grows by exactly 4*3+4*3+5 = 29 cycles.
4. start pulsed again while busy -> ignored; exactly NUM_NEURONS res_valid pulses and one done.
5. reset asserted during I_WRITE of neuron 1 -> next cycle all outputs 0, FSM IDLE; a fresh start (MAC also reset) produces correct results.
6. VEC_LEN=1, NUM_NEURONS=1; weight 0x40400000 (3.0), image 0xC0000000 (-2.0) -> res_data 0xC0C00000 (-6.0), res_index 0, done.
